// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch slice: default datapath widths,
// fetch FSM state type and the NOP instruction word.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} entries toward decode.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push/i_push_data write an entry (accepted when not full, or full with pop)
//   i_pop             remove head entry (ignored when empty)
//   i_flush           empty the FIFO; overrides push and pop that cycle
//   o_head            head entry (meaningful when !o_empty)
//   o_count           number of stored entries
//   o_full, o_empty   status flags
module if_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [WIDTH-1:0]             o_head,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = i_push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one word-addressed request at a time to
// instruction memory (req/gnt + rvalid), buffers returned words tagged with
// their PC, and stalls the PC register until a fetch is granted.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_pc / o_pc_stall            PC in; hold request back to PC register
//   i_flush                      redirect: drop buffered and in-flight fetches
//   o_imem_req/o_imem_addr       memory request and address (= i_pc)
//   i_imem_gnt                   request accepted
//   i_imem_rvalid/i_imem_rdata   returned instruction
//   o_inst_valid/o_inst/o_inst_pc  FIFO head toward decode
//   i_inst_ready                 decode consumes head
module if_fetch
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_pc_stall,
  input  logic              i_flush,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  output logic [DATA_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, count_after;
  logic [ENT_W-1:0]  fifo_head;

  assign fifo_pop     = !fifo_empty && i_inst_ready;
  assign o_inst_valid = !fifo_empty;
  assign o_inst_pc    = fifo_head[ENT_W-1:DATA_W];
  assign o_inst       = fifo_empty ? DATA_W'(NOP_INST) : fifo_head[DATA_W-1:0];
  assign o_imem_addr  = i_pc;
  assign o_pc_stall   = !(o_imem_req && i_imem_gnt);

  always_comb begin
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    o_imem_req  = 1'b0;
    fifo_push   = 1'b0;
    count_after = fifo_count;
    case (state_q)
      S_IDLE: begin
        if (!fifo_full && !i_flush) state_d = S_REQ;
      end
      S_REQ: begin
        o_imem_req = 1'b1;
        if (i_imem_gnt) begin
          pend_pc_d = i_pc;
          state_d   = i_flush ? S_DROP : S_WAIT;
        end else if (i_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_flush) begin
          // Response already here is dropped now; otherwise it is drained in S_DROP.
          state_d = i_imem_rvalid ? S_IDLE : S_DROP;
        end else if (i_imem_rvalid) begin
          fifo_push   = 1'b1;
          count_after = fifo_count + CNT_W'(1) - CNT_W'(fifo_pop);
          state_d     = (count_after < CNT_W'(DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (i_imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  if_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (fifo_push),
    .i_push_data ({pend_pc_q, i_imem_rdata}),
    .i_pop       (fifo_pop),
    .i_flush     (i_flush),
    .o_head      (fifo_head),
    .o_count     (fifo_count),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_pc = '0;
  logic        i_flush = 1'b0;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_inst_ready = 1'b0;
  logic        o_pc_stall, o_imem_req, o_inst_valid;
  logic [31:0] o_imem_addr, o_inst, o_inst_pc;

  always #5 clk = ~clk;

  if_fetch #(
    .DATA_W (32),
    .ADDR_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_pc          (i_pc),
    .o_pc_stall    (o_pc_stall),
    .i_flush       (i_flush),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst_valid  (o_inst_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .i_inst_ready  (i_inst_ready)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned pop_count = 0;
  exp_t        exp_q[$];

  // stimulus knobs
  int unsigned gnt_pct = 100, rdy_pct = 100, flush_pct = 0, min_dly = 0, max_dly = 0;
  bit          force_rst = 1'b1, force_flush = 1'b0, mon_on = 1'b0;

  // memory model state
  bit          mem_busy = 1'b0, tainted = 1'b0;
  logic [31:0] mem_pc = '0;
  int unsigned dly = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic void check(input bit ok, input string name,
                                input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Memory + PC register model. Each negedge predicts what the next posedge
  // does; a response is expected in decode order unless a flush or reset
  // hit its transaction between grant and return.
  initial begin
    logic [31:0] pc_nxt;
    forever begin
      @(negedge clk);
      if (mem_busy && i_imem_rvalid) begin
        mem_busy = 1'b0;
        if (!tainted && !i_flush && !i_rst)
          exp_q.push_back('{pc: mem_pc, inst: mem_fn(mem_pc), cyc: cyc});
      end else if (mem_busy && (i_flush || i_rst)) begin
        tainted = 1'b1;
      end
      if (o_imem_req === 1'b1 && i_imem_gnt) begin
        mem_busy = 1'b1;
        mem_pc   = i_pc;
        tainted  = i_flush || i_rst;
        dly      = $urandom_range(max_dly, min_dly);
      end
      if (i_rst)                    pc_nxt = '0;
      else if (i_flush)             pc_nxt = $urandom_range(1000, 0);
      else if (o_pc_stall === 1'b0) pc_nxt = i_pc + 32'd1;
      else                          pc_nxt = i_pc;

      @(posedge clk);
      #1;
      i_pc         = pc_nxt;
      i_rst        = force_rst;
      i_flush      = force_flush || ($urandom_range(99, 0) < flush_pct);
      i_inst_ready = ($urandom_range(99, 0) < rdy_pct);
      if (mem_busy) begin
        i_imem_gnt = 1'b0;
        if (dly == 0) begin
          i_imem_rvalid = 1'b1;
          i_imem_rdata  = mem_fn(mem_pc);
        end else begin
          dly--;
          i_imem_rvalid = 1'b0;
          i_imem_rdata  = $urandom;
        end
      end else begin
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = $urandom;
        i_imem_gnt    = ($urandom_range(99, 0) < gnt_pct);
      end
    end
  end

  // Monitor: compares the FIFO head and handshake outputs with the model.
  initial begin
    bit head;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        head = (exp_q.size() > 0) && (exp_q[0].cyc < cyc);
        check(o_inst_valid === head, "inst_valid", o_inst_valid, head);
        if (head && o_inst_valid === 1'b1) begin
          check(o_inst_pc === exp_q[0].pc, "inst_pc", o_inst_pc, exp_q[0].pc);
          check(o_inst === exp_q[0].inst, "inst_data", o_inst, exp_q[0].inst);
        end
        check(o_pc_stall === !(o_imem_req && i_imem_gnt), "pc_stall", o_pc_stall,
              !(o_imem_req && i_imem_gnt));
        if (o_imem_req === 1'b1)
          check(o_imem_addr === i_pc, "imem_addr", o_imem_addr, i_pc);
        if (o_imem_req === 1'b1 && i_imem_gnt && !i_rst)
          check(exp_q.size() < DEPTH, "issue_space", exp_q.size(), DEPTH - 1);
        if (i_rst || i_flush) begin
          exp_q.delete();
        end else if (head && o_inst_valid === 1'b1 && i_inst_ready) begin
          void'(exp_q.pop_front());
          pop_count++;
        end
      end else if (i_rst || i_flush) begin
        exp_q.delete();
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned p0;
    bit found;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check(o_inst_valid === 1'b0, "rst_inst_valid", o_inst_valid, 0);
    check(o_imem_req === 1'b0, "rst_imem_req", o_imem_req, 0);
    check(o_pc_stall === 1'b1, "rst_pc_stall", o_pc_stall, 1);
    mon_on = 1'b1;

    // steady fetch: one instruction every two cycles
    gnt_pct = 100; rdy_pct = 100; flush_pct = 0; min_dly = 0; max_dly = 0;
    force_rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    p0 = pop_count;
    repeat (40) @(negedge clk);
    #1;
    check((pop_count - p0) == 20, "throughput", pop_count - p0, 20);

    // backpressure: exactly DEPTH entries buffered, fetch halted
    rdy_pct = 0;
    repeat (20) @(negedge clk);
    #1;
    check(exp_q.size() == DEPTH, "bp_model_depth", exp_q.size(), DEPTH);
    check(o_imem_req === 1'b0, "bp_imem_req", o_imem_req, 0);
    check(o_pc_stall === 1'b1, "bp_pc_stall", o_pc_stall, 1);
    check(o_inst_valid === 1'b1, "bp_inst_valid", o_inst_valid, 1);
    rdy_pct = 100;
    repeat (10) @(negedge clk);

    // flush with full FIFO and simultaneous pop
    rdy_pct = 0;
    repeat (20) @(negedge clk);
    #1;
    check(o_inst_valid === 1'b1, "pre_flush_valid", o_inst_valid, 1);
    force_flush = 1'b1;
    rdy_pct = 100;
    @(posedge clk); #2;
    force_flush = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check(o_inst_valid === 1'b0, "flush_empties", o_inst_valid, 0);
    repeat (10) @(negedge clk);

    // reset while a response is in flight
    min_dly = 3; max_dly = 3; gnt_pct = 100;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #1;
      if (mem_busy && dly == 3) found = 1'b1;
    end
    check(found, "wait_inflight", found, 1);
    force_rst = 1'b1;
    @(posedge clk); #2;
    force_rst = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check(o_inst_valid === 1'b0, "rst_wait_valid", o_inst_valid, 0);
    check(o_imem_req === 1'b0, "rst_wait_idle", o_imem_req, 0);
    min_dly = 0;
    repeat (15) @(negedge clk);

    // randomized segments
    for (int s = 0; s < 15; s++) begin
      gnt_pct   = $urandom_range(100, 30);
      rdy_pct   = $urandom_range(100, 20);
      flush_pct = $urandom_range(15, 0);
      min_dly   = 0;
      max_dly   = $urandom_range(3, 0);
      repeat (200) @(negedge clk);
    end

    // drain
    flush_pct = 0; rdy_pct = 100; gnt_pct = 100;
    repeat (30) @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
